// File: rtl/pill_dispense_scheduler.sv
// Per-pill countdown scheduler: three interval timers share one dispenser through
// a round-robin REQ/RELOAD handshake, with timeout-based missed-dose tracking.
module pill_dispense_scheduler #(
   parameter int unsigned TIMEOUT_TICKS = 3
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        tick,
   input  logic        loadEn,
   input  logic [1:0]  loadPill,
   input  logic [3:0]  loadInterval,
   input  logic        dispenseAck,
   input  logic        clearMissed,
   output logic [11:0] pill12And3Durations,
   output logic        dispenseReq,
   output logic [1:0]  dispensePill,
   output logic [2:0]  missedFlags,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StReq, StReload} state_e;

   localparam logic [3:0] TimeoutVal = 4'(TIMEOUT_TICKS);

   state_e          state_q, state_d;
   logic [2:0][3:0] interval_q, interval_d;
   logic [2:0][3:0] remaining_q, remaining_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [1:0]      pill_q, pill_d;
   logic [3:0]      timer_q, timer_d;
   logic [2:0]      missed_q, missed_d;
   logic            req_q, req_d;

   logic [2:0] enabled, due, missed_set;
   logic       grant_valid, abort, reload_en, load_valid;
   logic [1:0] grant_pill;
   logic [2:0] rr_idx;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         enabled[i] = (interval_q[i] != 4'd0);
         due[i]     = enabled[i] && (remaining_q[i] == 4'd0);
      end
   end

   // Walk the candidates backwards so the first due pill in rrPtr order wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_pill  = 2'd0;
      rr_idx      = 3'd0;
      for (int k = 2; k >= 0; k--) begin
         rr_idx = {1'b0, rr_ptr_q} + 3'(k);
         if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
         if (due[rr_idx[1:0]]) begin
            grant_valid = 1'b1;
            grant_pill  = rr_idx[1:0];
         end
      end
   end

   assign load_valid = loadEn && (loadPill != 2'd3);
   assign abort      = load_valid && (loadPill == pill_q) && (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      interval_d  = interval_q;
      remaining_d = remaining_q;
      rr_ptr_d    = rr_ptr_q;
      pill_d      = pill_q;
      timer_d     = timer_q;
      req_d       = req_q;
      missed_set  = 3'b000;
      reload_en   = 1'b0;

      for (int i = 0; i < 3; i++) begin
         if (tick && enabled[i] && (remaining_q[i] != 4'd0)) begin
            remaining_d[i] = remaining_q[i] - 4'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               state_d = StReq;
               req_d   = 1'b1;
               pill_d  = grant_pill;
               timer_d = 4'd0;
            end
         end
         StReq: begin
            if (dispenseAck) begin
               state_d = StReload;
            end else if (timer_q == TimeoutVal) begin
               state_d            = StReload;
               missed_set[pill_q] = 1'b1;
            end else if (tick) begin
               timer_d = timer_q + 4'd1;
            end
         end
         StReload: begin
            req_d     = 1'b0;
            reload_en = 1'b1;
            rr_ptr_d  = (pill_q == 2'd2) ? 2'd0 : pill_q + 2'd1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d    = StIdle;
         req_d      = 1'b0;
         missed_set = 3'b000;
         reload_en  = 1'b0;
         rr_ptr_d   = rr_ptr_q;
      end

      if (reload_en) remaining_d[pill_q] = interval_q[pill_q];

      // A host load overrides both the reload and the tick for that pill.
      if (load_valid) begin
         interval_d[loadPill]  = loadInterval;
         remaining_d[loadPill] = loadInterval;
      end

      missed_d = (clearMissed ? 3'b000 : missed_q) | missed_set;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= StIdle;
         interval_q  <= '0;
         remaining_q <= '0;
         rr_ptr_q    <= 2'd0;
         pill_q      <= 2'd0;
         timer_q     <= 4'd0;
         missed_q    <= 3'b000;
         req_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         interval_q  <= interval_d;
         remaining_q <= remaining_d;
         rr_ptr_q    <= rr_ptr_d;
         pill_q      <= pill_d;
         timer_q     <= timer_d;
         missed_q    <= missed_d;
         req_q       <= req_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         pill12And3Durations[i*4 +: 4] = enabled[i] ? remaining_q[i] : 4'hF;
      end
   end

   assign dispenseReq  = req_q;
   assign dispensePill = pill_q;
   assign missedFlags  = missed_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_pill_dispense_scheduler.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle against a
// procedural model of the countdown, round-robin and timeout rules.
module tb_pill_dispense_scheduler;

   localparam int T = 3;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        tick = 1'b0;
   logic        loadEn = 1'b0;
   logic [1:0]  loadPill = 2'd0;
   logic [3:0]  loadInterval = 4'd0;
   logic        dispenseAck = 1'b0;
   logic        clearMissed = 1'b0;
   logic [11:0] pill12And3Durations;
   logic        dispenseReq;
   logic [1:0]  dispensePill;
   logic [2:0]  missedFlags;
   logic        busy;

   pill_dispense_scheduler #(.TIMEOUT_TICKS(T)) dut (
      .clk                 (clk),
      .resetN              (resetN),
      .tick                (tick),
      .loadEn              (loadEn),
      .loadPill            (loadPill),
      .loadInterval        (loadInterval),
      .dispenseAck         (dispenseAck),
      .clearMissed         (clearMissed),
      .pill12And3Durations (pill12And3Durations),
      .dispenseReq         (dispenseReq),
      .dispensePill        (dispensePill),
      .missedFlags         (missedFlags),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: a request is outstanding from grant until the reload finishes.
   int       m_int[3];
   int       m_rem[3];
   bit       m_busy, m_rel;
   int       m_pill, m_rr, m_timer;
   bit [2:0] m_missed;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_int[i] = 0;
         m_rem[i] = 0;
      end
      m_busy = 0; m_rel = 0; m_pill = 0; m_rr = 0; m_timer = 0; m_missed = 3'b000;
   endtask

   task automatic model_step();
      int       n_int[3];
      int       n_rem[3];
      bit       abort;
      bit [2:0] set;
      int       sel;
      int       c;
      n_int = m_int;
      n_rem = m_rem;
      set   = 3'b000;
      abort = loadEn && (loadPill != 2'd3) && (int'(loadPill) == m_pill) && m_busy;
      for (int i = 0; i < 3; i++)
         if (tick && m_int[i] != 0 && m_rem[i] > 0) n_rem[i] = m_rem[i] - 1;
      if (abort) begin
         m_busy = 0;
         m_rel  = 0;
      end else if (!m_busy) begin
         sel = -1;
         for (int k = 0; k < 3; k++) begin
            c = (m_rr + k) % 3;
            if (sel < 0 && m_int[c] != 0 && m_rem[c] == 0) sel = c;
         end
         if (sel >= 0) begin
            m_busy  = 1;
            m_pill  = sel;
            m_timer = 0;
         end
      end else if (m_rel) begin
         n_rem[m_pill] = m_int[m_pill];
         m_rr   = (m_pill + 1) % 3;
         m_busy = 0;
         m_rel  = 0;
      end else begin
         if (dispenseAck) m_rel = 1;
         else if (m_timer == T) begin
            set[m_pill] = 1'b1;
            m_rel = 1;
         end else if (tick) m_timer = m_timer + 1;
      end
      if (loadEn && loadPill != 2'd3) begin
         n_int[loadPill] = int'(loadInterval);
         n_rem[loadPill] = int'(loadInterval);
      end
      m_missed = (clearMissed ? 3'b000 : m_missed) | set;
      m_int = n_int;
      m_rem = n_rem;
   endtask

   function automatic logic [11:0] exp_dur();
      logic [11:0] e;
      for (int i = 0; i < 3; i++) e[i*4 +: 4] = (m_int[i] != 0) ? 4'(m_rem[i]) : 4'hF;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("durations", 32'(pill12And3Durations), 32'(exp_dur()));
      check("req", 32'(dispenseReq), 32'(m_busy));
      check("pill", 32'(dispensePill), 32'(m_pill));
      check("missed", 32'(missedFlags), 32'(m_missed));
      check("busy", 32'(busy), 32'(m_busy));
   endtask

   task automatic do_cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic load(input logic [1:0] p, input logic [3:0] v);
      loadEn = 1'b1;
      loadPill = p;
      loadInterval = v;
      do_cycle();
      loadEn = 1'b0;
   endtask

   // Called 1 time unit after an edge; resets mid-cycle and releases before the next edge.
   task automatic async_reset(input string tag);
      #2 resetN = 1'b0;
      #1;
      model_reset();
      check({tag, "_req"}, 32'(dispenseReq), 32'd0);
      check({tag, "_dur"}, 32'(pill12And3Durations), 32'hFFF);
      compare_all();
      #1 resetN = 1'b1;
   endtask

   int order[$];
   int exp_order[3] = '{1, 2, 0};
   bit prev_req;

   initial begin
      model_reset();
      #12;
      check("reset_dur", 32'(pill12And3Durations), 32'hFFF);
      compare_all();
      resetN = 1'b1;

      // Countdown and first grant.
      load(2'd0, 4'd2);
      check("load_p0", 32'(pill12And3Durations[3:0]), 32'd2);
      tick = 1'b1;
      do_cycle();
      check("cnt_1", 32'(pill12And3Durations[3:0]), 32'd1);
      do_cycle();
      check("cnt_0", 32'(pill12And3Durations[3:0]), 32'd0);
      check("no_req_yet", 32'(dispenseReq), 32'd0);
      tick = 1'b0;
      do_cycle();
      check("grant_req", 32'(dispenseReq), 32'd1);
      check("grant_pill", 32'(dispensePill), 32'd0);

      // Ack and reload.
      dispenseAck = 1'b1;
      do_cycle();
      do_cycle();
      dispenseAck = 1'b0;
      check("ack_req_drop", 32'(dispenseReq), 32'd0);
      check("ack_reload", 32'(pill12And3Durations[3:0]), 32'd2);
      check("ack_idle", 32'(busy), 32'd0);

      // All three due with rrPtr=1.
      load(2'd0, 4'd1);
      load(2'd1, 4'd1);
      load(2'd2, 4'd1);
      tick = 1'b1;
      do_cycle();
      tick = 1'b0;
      check("all_due", 32'(pill12And3Durations), 32'h000);
      dispenseAck = 1'b1;
      prev_req = 1'b0;
      for (int c = 0; c < 30 && order.size() < 3; c++) begin
         do_cycle();
         if (dispenseReq && !prev_req) order.push_back(int'(dispensePill));
         prev_req = dispenseReq;
      end
      dispenseAck = 1'b0;
      check("rr_count", 32'(order.size()), 32'd3);
      for (int k = 0; k < order.size() && k < 3; k++) check("rr_order", 32'(order[k]), 32'(exp_order[k]));

      // Pill0 now in REQ with no ack: timeout after T ticks.
      tick = 1'b1;
      for (int k = 0; k < T; k++) do_cycle();
      tick = 1'b0;
      check("pre_timeout", 32'(missedFlags), 32'd0);
      do_cycle();
      check("timeout_missed", 32'(missedFlags), 32'b001);
      do_cycle();
      check("timeout_reload", 32'(pill12And3Durations[3:0]), 32'd1);
      clearMissed = 1'b1;
      do_cycle();
      clearMissed = 1'b0;
      check("clear_missed", 32'(missedFlags), 32'd0);
      check("p1_req", 32'(dispenseReq), 32'd1);
      check("p1_pill", 32'(dispensePill), 32'd1);

      // Abort by reloading the requested pill.
      load(2'd1, 4'd5);
      check("abort_req", 32'(dispenseReq), 32'd0);
      check("abort_dur", 32'(pill12And3Durations[7:4]), 32'd5);
      check("abort_missed", 32'(missedFlags), 32'd0);
      do_cycle();
      check("p2_pill", 32'(dispensePill), 32'd2);
      async_reset("rst_req");

      load(2'd2, 4'd3);
      check("p2_load", 32'(pill12And3Durations[11:8]), 32'd3);
      load(2'd2, 4'd0);
      check("p2_disable", 32'(pill12And3Durations[11:8]), 32'hF);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         tick         = ($urandom_range(0, 2) == 0);
         loadEn       = ($urandom_range(0, 11) == 0);
         loadPill     = 2'($urandom_range(0, 3));
         loadInterval = 4'($urandom_range(0, 5));
         dispenseAck  = ($urandom_range(0, 4) == 0);
         clearMissed  = ($urandom_range(0, 19) == 0);
         do_cycle();
         if ($urandom_range(0, 399) == 0) async_reset("rst_rand");
      end
      tick = 1'b0; loadEn = 1'b0; dispenseAck = 1'b0; clearMissed = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
